matrix_result_sender: RTL and testbench

Streams a captured 3x3 result matrix (nine 8-bit elements, flattened to 72 bits) out through the byte-wide UART transmitter, one element per transmitter frame. Sits directly downstream of the matrix multiplier and directly upstream of the UART transmitter. Replaces ad-hoc send sequencing in the top level with a clean load/done handshake. Also tolerates a transmitter running on a slower baud clock.

---
 rtl/matrix_result_sender_if.sv | 32 +++
 rtl/matrix_result_sender.sv | 165 ++++++++++++++++
 tb/tb_matrix_result_sender.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_result_sender_if.sv
`default_nettype none
// ============================================================================
// matrix_result_sender_if
// Load/done handshake plus transmitter request/busy signals for the sender.
// Revision: 1.0
// ============================================================================
interface matrix_result_sender_if #(
  parameter int N_ELEM = 9
);
  logic                  load;
  logic [8*N_ELEM-1:0]   c_flat;
  logic                  tx_busy;
  logic                  ready;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic [3:0]            byte_idx;
  logic                  done;
  logic                  err;

  // Sender side
  modport slave (
    input  load, c_flat, tx_busy,
    output ready, tx_start, tx_data, byte_idx, done, err
  );

  // Requester / transmitter side
  modport master (
    output load, c_flat, tx_busy,
    input  ready, tx_start, tx_data, byte_idx, done, err
  );
endinterface
`default_nettype wire

// File: rtl/matrix_result_sender.sv
`default_nettype none
// ============================================================================
// matrix_result_sender
// Streams a captured 3x3 result matrix, one byte per UART frame, LSB-first.
// Optional MATRIX_TX_CHECKSUM_EN: appends a modulo-256 sum byte.
// Revision: 1.0
// ============================================================================
module matrix_result_sender #(
  parameter int N_ELEM      = 9,
  parameter int ACK_TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_result_sender_if.slave bus
);

  localparam int c_W = 8 * N_ELEM;
`ifdef MATRIX_TX_CHECKSUM_EN
  localparam logic [3:0] c_LAST = 4'(N_ELEM);
`else
  localparam logic [3:0] c_LAST = 4'(N_ELEM - 1);
`endif
  localparam bit          c_TO_EN   = (ACK_TIMEOUT != 0);
  localparam logic [19:0] c_TO_LAST = (ACK_TIMEOUT == 0) ? 20'd0 : 20'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [c_W-1:0]   r_shadow;
  logic [19:0]      r_cnt;
  logic             r_busy_meta;
  logic             r_busy_s;
  logic             r_busy_q;
  logic             r_ready;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic [3:0]       r_byte_idx;
  logic             r_done;
  logic             r_err;
`ifdef MATRIX_TX_CHECKSUM_EN
  logic [7:0]       r_sum;
`endif

  logic             w_rise;
  logic             w_fall;
  logic             w_timeout;
  logic [6:0]       w_off;
  logic [7:0]       w_elem;
  logic [7:0]       w_byte;

  // tx_busy may come from the baud domain, so it is resynchronised first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy_meta <= 1'b0;
      r_busy_s    <= 1'b0;
      r_busy_q    <= 1'b0;
    end else begin
      r_busy_meta <= bus.tx_busy;
      r_busy_s    <= r_busy_meta;
      r_busy_q    <= r_busy_s;
    end
  end

  assign w_rise    = r_busy_s & ~r_busy_q;
  assign w_fall    = ~r_busy_s & r_busy_q;
  assign w_timeout = c_TO_EN && (r_cnt == c_TO_LAST);
  assign w_off     = {r_byte_idx, 3'b000};
  assign w_elem    = r_shadow[w_off +: 8];
`ifdef MATRIX_TX_CHECKSUM_EN
  assign w_byte    = (r_byte_idx == c_LAST) ? r_sum : w_elem;
`else
  assign w_byte    = w_elem;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shadow   <= '0;
      r_cnt      <= '0;
      r_ready    <= 1'b1;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_byte_idx <= 4'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef MATRIX_TX_CHECKSUM_EN
      r_sum      <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // ready is still low on the cycle after DONE, so load there is dropped
          if (bus.load && r_ready) begin
            r_shadow   <= bus.c_flat;
            r_byte_idx <= 4'd0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
`ifdef MATRIX_TX_CHECKSUM_EN
            r_sum      <= 8'h00;
`endif
            r_state    <= S_REQ;
          end else begin
            r_ready    <= 1'b1;
          end
        end
        S_REQ: begin
          if (w_rise) begin
            r_tx_start <= 1'b0;
`ifdef MATRIX_TX_CHECKSUM_EN
            r_sum      <= r_sum + r_tx_data;
`endif
            r_state    <= S_WAIT;
          end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_tx_start <= 1'b0;
            r_ready    <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
            r_cnt      <= r_cnt + 20'd1;
          end
        end
        S_WAIT: begin
          if (w_fall) begin
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_byte_idx == c_LAST) begin
            r_state    <= S_DONE;
          end else begin
            r_byte_idx <= r_byte_idx + 4'd1;
            r_cnt      <= '0;
            r_state    <= S_REQ;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
  assign bus.byte_idx = r_byte_idx;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_sender.sv
`default_nettype none
// ============================================================================
// tb_matrix_result_sender
// Scoreboarded bench with a frame-level UART transmitter model.
// Revision: 1.0
// ============================================================================
module tb_matrix_result_sender;

  localparam int ACK = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matrix_result_sender_if #(.N_ELEM(9)) ifc ();

  matrix_result_sender #(
    .N_ELEM      (9),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  logic [7:0] exp_q[$];
  int         exp_idx_q[$];
  int         checks     = 0;
  int         errors     = 0;
  int         done_count = 0;
  bit         model_en   = 1'b1;
  bit         stale_busy = 1'b0;
  bit         rand_len   = 1'b0;
  bit         model_busy = 1'b0;
  int         frame_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Expected byte stream for one matrix: elements in order, then the sum byte
  function automatic void push_matrix(input logic [71:0] m);
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(m[8*k +: 8]);
      exp_idx_q.push_back(k);
    end
`ifdef MATRIX_TX_CHECKSUM_EN
    begin
      int sum;
      sum = 0;
      for (int k = 0; k < 9; k++) sum += int'(m[8*k +: 8]);
      exp_q.push_back(8'(sum % 256));
      exp_idx_q.push_back(9);
    end
`endif
  endfunction

  // Transmitter model and monitor: accepts a frame when tx_start is seen idle
  always @(negedge clk) begin : p_tx_model
    logic [7:0] e;
    int         ei;
    if (reset) begin
      frame_cnt  = 0;
      model_busy = 1'b0;
    end else begin
      if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) model_busy = 1'b0;
      end else if (model_en && ifc.tx_start && !ifc.tx_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'h0, ifc.tx_data}, 32'hFFFF_FFFF);
        end else begin
          e  = exp_q.pop_front();
          ei = exp_idx_q.pop_front();
          check("tx_data", {24'h0, ifc.tx_data}, {24'h0, e});
          check("byte_idx", {28'h0, ifc.byte_idx}, ei);
        end
        model_busy = 1'b1;
        frame_cnt  = rand_len ? int'($urandom_range(10, 50)) : 50;
      end
      if (ifc.done) begin
        done_count++;
        check("done_queue_empty", exp_q.size(), 0);
      end
    end
    ifc.tx_busy = model_busy | stale_busy;
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ifc.ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [71:0] m, input bit expect_bytes);
    wait_ready();
    ifc.c_flat = m;
    ifc.load   = 1'b1;
    if (expect_bytes) push_matrix(m);
    @(negedge clk);
    ifc.load   = 1'b0;
    ifc.c_flat = {$urandom, $urandom, 8'($urandom)};
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_count < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done_count, target);
    repeat (6) @(negedge clk);
    check("done_once", done_count, target);
    check("err_clear", ifc.err, 0);
    check("ready_after_done", ifc.ready, 1);
  endtask

  task automatic wait_for_idx_wait(input int idx);
    int n;
    n = 0;
    while (!(ifc.byte_idx == 4'(idx) && ifc.tx_busy && !ifc.tx_start) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("reach_byte_wait", ifc.byte_idx, idx);
  endtask

  initial begin
    logic [71:0] m;
    int          d;
    int          n;

    reset      = 1'b1;
    ifc.load   = 1'b0;
    ifc.c_flat = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ifc.ready, 1);
    check("rst_tx_start", ifc.tx_start, 0);
    check("rst_tx_data", ifc.tx_data, 0);
    check("rst_byte_idx", ifc.byte_idx, 0);
    check("rst_done", ifc.done, 0);
    check("rst_err", ifc.err, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Elements 0x01..0x09, fixed 50-cycle frames; first byte two edges after load
    m = {8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    d = done_count;
    send(m, 1'b1);
    @(negedge clk);
    check("first_tx_start", ifc.tx_start, 1);
    check("first_tx_data", ifc.tx_data, 32'h01);
    wait_done(d + 1);

    // All 0xFF
    m = {9{8'hFF}};
    d = done_count;
    send(m, 1'b1);
    wait_done(d + 1);

    // Random data and frame lengths
    rand_len = 1'b1;
    for (int it = 0; it < 4; it++) begin
      m = {$urandom, $urandom, 8'($urandom)};
      d = done_count;
      send(m, 1'b1);
      wait_done(d + 1);
    end

    // Second load during byte 3 is ignored
    m = {$urandom, $urandom, 8'($urandom)};
    d = done_count;
    send(m, 1'b1);
    n = 0;
    while (ifc.byte_idx != 4'd3 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("reach_byte3", ifc.byte_idx, 3);
    ifc.c_flat = ~m;
    ifc.load   = 1'b1;
    @(negedge clk);
    ifc.load   = 1'b0;
    wait_done(d + 1);

    // Reset while waiting on byte 5
    m = {$urandom, $urandom, 8'($urandom)};
    send(m, 1'b1);
    wait_for_idx_wait(5);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", ifc.ready, 1);
    check("mid_rst_tx_start", ifc.tx_start, 0);
    check("mid_rst_tx_data", ifc.tx_data, 0);
    check("mid_rst_byte_idx", ifc.byte_idx, 0);
    check("mid_rst_done", ifc.done, 0);
    check("mid_rst_err", ifc.err, 0);
    exp_q.delete();
    exp_idx_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    m = {$urandom, $urandom, 8'($urandom)};
    d = done_count;
    send(m, 1'b1);
    wait_done(d + 1);

    // Stale busy on load: nothing counted until a fresh rise/fall
    stale_busy = 1'b1;
    repeat (4) @(negedge clk);
    m = {$urandom, $urandom, 8'($urandom)};
    d = done_count;
    send(m, 1'b1);
    repeat (20) @(negedge clk);
    check("stale_no_advance_idx", ifc.byte_idx, 0);
    check("stale_still_requesting", ifc.tx_start, 1);
    stale_busy = 1'b0;
    wait_done(d + 1);

    // Acknowledge timeout with the transmitter silent
    model_en = 1'b0;
    d = done_count;
    send({$urandom, $urandom, 8'($urandom)}, 1'b0);
    n = 0;
    while (!ifc.tx_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_tx_start_seen", ifc.tx_start, 1);
    n = 0;
    while (!ifc.err && n < 3 * ACK) begin
      @(negedge clk);
      n++;
    end
    check("to_err_set", ifc.err, 1);
    check("to_latency_window", (n >= ACK - 2 && n <= ACK + 1), 1);
    check("to_tx_start_low", ifc.tx_start, 0);
    check("to_ready", ifc.ready, 1);
    repeat (20) @(negedge clk);
    check("to_no_done", done_count, d);
    check("to_err_sticky", ifc.err, 1);
    model_en = 1'b1;

    // Next accepted load clears err and completes normally
    m = {$urandom, $urandom, 8'($urandom)};
    send(m, 1'b1);
    check("err_cleared_by_load", ifc.err, 0);
    wait_done(d + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
